// File: rtl/cache_req_gen_if.sv
// -----------------------------------------------------------------------------
// cache_req_gen_if
//
// CPU-side request bus between the request generator and the L1 cache.
//
//   a        [31:0]  request byte address            (generator -> cache)
//   be       [3:0]   request byte enables            (generator -> cache)
//   read             read request, level             (generator -> cache)
//   write            write request, level            (generator -> cache)
//   wd       [31:0]  write data                      (generator -> cache)
//   rd       [31:0]  read data                       (cache -> generator)
//   rd_valid         rd is valid this cycle          (cache -> generator)
//   req_hit          cache accepts current request   (cache -> generator)
//
// master: request initiator side.  slave: cache (or bench responder) side.
// -----------------------------------------------------------------------------
interface cache_req_gen_if;
  logic [31:0] a;
  logic [3:0]  be;
  logic        read;
  logic        write;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rd_valid;
  logic        req_hit;

  modport master (
    output a, be, read, write, wd,
    input  rd, rd_valid, req_hit
  );

  modport slave (
    input  a, be, read, write, wd,
    output rd, rd_valid, req_hit
  );
endinterface

// File: rtl/cache_req_gen.sv
// -----------------------------------------------------------------------------
// cache_req_gen
//
// Request initiator for the L1 cache. Commands are queued in a small FIFO and
// issued one at a time on the cache request bus. Each request is held with
// stable address/enables/data until the cache accepts it (req_hit). Read data
// is compared against the expected value under the byte-enable mask, and the
// block keeps completion and error statistics. A request that waits too long
// for acceptance or read data halts the block until reset.
//
// Parameters
//   DEPTH    command FIFO entries (power of two, >= 2)
//   TIMEOUT  max cycles a request may wait for req_hit / rd_valid
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-low
//   cmd_valid  command push request
//   cmd_ready  FIFO can accept (not full, not halted, out of reset)
//   cmd_op     0 = read, 1 = write
//   cmd_chk    compare returned data (reads only)
//   cmd_addr   byte address
//   cmd_be     byte enables
//   cmd_data   write data or expected read data
//   bus        cache request bus (master side)
//   busy       FIFO non-empty or request outstanding
//   done_cnt   completed commands, saturating
//   err_cnt    read compare mismatches, saturating
//   err        one-cycle pulse on a mismatching completion
//   err_addr   address of most recent mismatch
//   err_data   returned data of most recent mismatch
//   timeout    sticky timeout flag
// -----------------------------------------------------------------------------
module cache_req_gen #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic            cmd_chk,
  input  logic [31:0]     cmd_addr,
  input  logic [3:0]      cmd_be,
  input  logic [31:0]     cmd_data,
  cache_req_gen_if.master bus,
  output logic            busy,
  output logic [15:0]     done_cnt,
  output logic [15:0]     err_cnt,
  output logic            err,
  output logic [31:0]     err_addr,
  output logic [31:0]     err_data,
  output logic            timeout
);

  localparam int AW     = $clog2(DEPTH);
  localparam int TW_MIN = $clog2(TIMEOUT + 1);
  localparam int TW     = (TW_MIN > 8) ? TW_MIN : 8;
  // Halt is taken on the edge where the counter would reach TIMEOUT, so the
  // request is visible for exactly TIMEOUT cycles.
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef struct packed {
    logic        op;
    logic        chk;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    HALT    = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Command FIFO. Pointers carry one extra wrap bit to tell full from empty.
  // The head is read combinationally so an entry pushed at one edge can be
  // loaded into the request registers at the very next edge.
  // ---------------------------------------------------------------------------
  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  cmd_t          head;
  cmd_t          push_entry;

  assign empty      = (wr_ptr_reg == rd_ptr_reg);
  assign full       = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign head       = mem[rd_ptr_reg[AW-1:0]];
  assign push_entry = {cmd_op, cmd_chk, cmd_addr, cmd_be, cmd_data};
  assign push       = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Request / status registers
  // ---------------------------------------------------------------------------
  state_t        state_reg;
  logic [TW-1:0] tcnt_reg;
  logic          op_reg;
  logic          chk_reg;
  logic [31:0]   a_reg;
  logic [3:0]    be_reg;
  logic [31:0]   wd_reg;
  logic [31:0]   exp_reg;
  logic          read_reg;
  logic          write_reg;
  logic          ready_en_reg;
  logic [15:0]   done_cnt_reg;
  logic [15:0]   err_cnt_reg;
  logic          err_reg;
  logic [31:0]   err_addr_reg;
  logic [31:0]   err_data_reg;
  logic          timeout_reg;

  // Per-byte compare: a byte only counts when its enable is set.
  logic [3:0]    byte_miss;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_cmp
      assign byte_miss[gi] = be_reg[gi] &
                             (bus.rd[8*gi +: 8] != exp_reg[8*gi +: 8]);
    end
  endgenerate

  logic accept;
  logic complete;
  logic mismatch;

  // A read accepted together with rd_valid completes at once; otherwise the
  // read finishes later in WAIT_RD. rd_valid is ignored in any other state.
  assign accept   = (state_reg == ISSUE) & bus.req_hit;
  assign complete = (accept & (op_reg | bus.rd_valid)) |
                    ((state_reg == WAIT_RD) & bus.rd_valid);
  assign mismatch = complete & ~op_reg & chk_reg & (|byte_miss);
  assign pop      = ~empty & ((state_reg == IDLE) | complete);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      tcnt_reg     <= '0;
      op_reg       <= 1'b0;
      chk_reg      <= 1'b0;
      a_reg        <= '0;
      be_reg       <= '0;
      wd_reg       <= '0;
      exp_reg      <= '0;
      read_reg     <= 1'b0;
      write_reg    <= 1'b0;
      ready_en_reg <= 1'b0;
      done_cnt_reg <= '0;
      err_cnt_reg  <= '0;
      err_reg      <= 1'b0;
      err_addr_reg <= '0;
      err_data_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      err_reg      <= 1'b0;

      case (state_reg)
        ISSUE: begin
          if (accept) begin
            tcnt_reg <= '0;
            if (!complete) begin
              state_reg <= WAIT_RD;
              read_reg  <= 1'b0;
            end
          end else if (tcnt_reg == TIMEOUT_LAST) begin
            state_reg   <= HALT;
            read_reg    <= 1'b0;
            write_reg   <= 1'b0;
            timeout_reg <= 1'b1;
          end else begin
            tcnt_reg <= tcnt_reg + 1'b1;
          end
        end
        WAIT_RD: begin
          if (!bus.rd_valid) begin
            if (tcnt_reg == TIMEOUT_LAST) begin
              state_reg   <= HALT;
              timeout_reg <= 1'b1;
            end else begin
              tcnt_reg <= tcnt_reg + 1'b1;
            end
          end
        end
        default: begin
          // IDLE waits for a pop below; HALT is left only through reset.
        end
      endcase

      if (complete) begin
        state_reg <= IDLE;
        read_reg  <= 1'b0;
        write_reg <= 1'b0;
        if (done_cnt_reg != 16'hFFFF) done_cnt_reg <= done_cnt_reg + 16'd1;
        if (mismatch) begin
          err_reg      <= 1'b1;
          err_addr_reg <= a_reg;
          err_data_reg <= bus.rd;
          if (err_cnt_reg != 16'hFFFF) err_cnt_reg <= err_cnt_reg + 16'd1;
        end
      end

      // Loading the next command overrides the return to IDLE above, which
      // gives back-to-back issue without a bubble.
      if (pop) begin
        state_reg <= ISSUE;
        tcnt_reg  <= '0;
        op_reg    <= head.op;
        chk_reg   <= head.chk;
        a_reg     <= head.addr;
        be_reg    <= head.be;
        wd_reg    <= head.op ? head.data : 32'd0;
        exp_reg   <= head.data;
        read_reg  <= ~head.op;
        write_reg <= head.op;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready = ready_en_reg & ~full & (state_reg != HALT);
  assign busy      = ~empty | (state_reg != IDLE);
  assign bus.a     = a_reg;
  assign bus.be    = be_reg;
  assign bus.wd    = wd_reg;
  assign bus.read  = read_reg;
  assign bus.write = write_reg;
  assign done_cnt  = done_cnt_reg;
  assign err_cnt   = err_cnt_reg;
  assign err       = err_reg;
  assign err_addr  = err_addr_reg;
  assign err_data  = err_data_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_cache_req_gen.sv
// -----------------------------------------------------------------------------
// tb_cache_req_gen
//
// Directed scenarios plus a randomized command stream for cache_req_gen. The
// bench plays the cache: it answers requests with random acceptance and
// read-data delays, and keeps its own queue of issued commands to predict bus
// contents, completion counts and byte-masked compare errors.
// -----------------------------------------------------------------------------
module tb_cache_req_gen;
  localparam int TO = 16;

  typedef struct packed {
    logic        op;
    logic        chk;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic        cmd_chk = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_data = '0;
  logic        busy;
  logic [15:0] done_cnt;
  logic [15:0] err_cnt;
  logic        err;
  logic [31:0] err_addr;
  logic [31:0] err_data;
  logic        timeout;

  cache_req_gen_if bus_if();

  cache_req_gen #(.DEPTH(8), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_chk  (cmd_chk),
    .cmd_addr (cmd_addr),
    .cmd_be   (cmd_be),
    .cmd_data (cmd_data),
    .bus      (bus_if),
    .busy     (busy),
    .done_cnt (done_cnt),
    .err_cnt  (err_cnt),
    .err      (err),
    .err_addr (err_addr),
    .err_data (err_data),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done = 0;
  int exp_err  = 0;

  // Reference compare rule: any enabled byte that differs is an error.
  function automatic bit model_miss(input cmd_t c, input logic [31:0] rdv);
    logic [31:0] mask;
    mask = '0;
    if (c.op || !c.chk) return 1'b0;
    for (int b = 0; b < 4; b++) if (c.be[b]) mask = mask | (32'hFF << (8 * b));
    return ((rdv ^ c.data) & mask) != 32'd0;
  endfunction

  // Called just after a falling edge; returns after the push edge.
  task automatic push_cmd(input cmd_t c);
    int guard;
    guard = 0;
    cmd_valid = 1'b1; cmd_op = c.op; cmd_chk = c.chk;
    cmd_addr = c.addr; cmd_be = c.be; cmd_data = c.data;
    while (!cmd_ready && guard < 200) begin @(negedge clk); guard++; end
    n_tests++;
    if (guard >= 200) begin
      n_fail++; $display("FAIL push_cmd: cmd_ready=%0b, required 1", cmd_ready);
    end else begin
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus_if.read || bus_if.write) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    bus_if.req_hit = 1'b0; bus_if.rd_valid = 1'b0; bus_if.rd = '0;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({cmd_ready, busy, bus_if.read, bus_if.write, err, timeout} !== 6'b0 ||
        done_cnt !== 16'd0 || err_cnt !== 16'd0 || bus_if.a !== 32'd0) begin
      n_fail++; $display("FAIL reset_outputs: ready=%0b busy=%0b rd=%0b wr=%0b done=%0d a=%h, required all 0",
                         cmd_ready, busy, bus_if.read, bus_if.write, done_cnt, bus_if.a);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: ready=%0b busy=%0b, required 1/0", cmd_ready, busy);
    end
    exp_done = 0; exp_err = 0;
  endtask

  task automatic test_write;
    cmd_t c; bit ok;
    c = '{op: 1'b1, chk: 1'b0, addr: 32'h100, be: 4'hF, data: 32'hA5A5A5A5};
    push_cmd(c);
    wait_req(ok);
    n_tests++;
    if (!ok || bus_if.write !== 1'b1 || bus_if.read !== 1'b0 || bus_if.a !== 32'h100 ||
        bus_if.wd !== 32'hA5A5A5A5 || bus_if.be !== 4'hF) begin
      n_fail++; $display("FAIL write_issue: wr=%0b a=%h wd=%h be=%h, required 1/100/a5a5a5a5/f",
                         bus_if.write, bus_if.a, bus_if.wd, bus_if.be);
    end
    bus_if.req_hit = 1'b1;
    @(negedge clk);
    bus_if.req_hit = 1'b0;
    exp_done++;
    n_tests++;
    if (bus_if.write !== 1'b0 || done_cnt !== 16'(exp_done) || busy !== 1'b0) begin
      n_fail++; $display("FAIL write_done: wr=%0b done=%0d busy=%0b, required 0/%0d/0",
                         bus_if.write, done_cnt, busy, exp_done);
    end
  endtask

  task automatic test_read;
    cmd_t c; bit ok; bit seen_err;
    c = '{op: 1'b0, chk: 1'b1, addr: 32'h200, be: 4'hF, data: 32'hDEADBEEF};
    push_cmd(c);
    wait_req(ok);
    n_tests++;
    if (!ok || bus_if.read !== 1'b1 || bus_if.a !== 32'h200) begin
      n_fail++; $display("FAIL read_issue: rd=%0b a=%h, required 1/200", bus_if.read, bus_if.a);
    end
    bus_if.req_hit = 1'b1;
    @(negedge clk);
    bus_if.req_hit = 1'b0;
    seen_err = err;
    n_tests++;
    if (bus_if.read !== 1'b0 || busy !== 1'b1 || done_cnt !== 16'(exp_done)) begin
      n_fail++; $display("FAIL read_wait: rd=%0b busy=%0b done=%0d, required 0/1/%0d",
                         bus_if.read, busy, done_cnt, exp_done);
    end
    bus_if.rd_valid = 1'b1; bus_if.rd = 32'hDEADBEEF;
    @(negedge clk);
    bus_if.rd_valid = 1'b0;
    seen_err = seen_err | err;
    exp_done++;
    n_tests++;
    if (seen_err !== 1'b0 || done_cnt !== 16'(exp_done) || err_cnt !== 16'(exp_err) || busy !== 1'b0) begin
      n_fail++; $display("FAIL read_done: err=%0b done=%0d err_cnt=%0d busy=%0b, required 0/%0d/%0d/0",
                         seen_err, done_cnt, err_cnt, busy, exp_done, exp_err);
    end
  endtask

  task automatic test_be_mask;
    cmd_t c; bit ok;
    logic [31:0] addr2;
    c = '{op: 1'b0, chk: 1'b1, addr: 32'h300, be: 4'b0011, data: 32'hFFFF5678};
    push_cmd(c);
    wait_req(ok);
    bus_if.req_hit = 1'b1; bus_if.rd_valid = 1'b1; bus_if.rd = 32'h12345678;
    @(negedge clk);
    bus_if.req_hit = 1'b0; bus_if.rd_valid = 1'b0;
    exp_done++;
    n_tests++;
    if (!ok || err !== 1'b0 || err_cnt !== 16'(exp_err) || done_cnt !== 16'(exp_done)) begin
      n_fail++; $display("FAIL be_mask_match: err=%0b err_cnt=%0d done=%0d, required 0/%0d/%0d",
                         err, err_cnt, done_cnt, exp_err, exp_done);
    end
    addr2 = $urandom() & 32'hFFFF_FFFC;
    c = '{op: 1'b0, chk: 1'b1, addr: addr2, be: 4'b0011, data: 32'h12340000};
    push_cmd(c);
    wait_req(ok);
    bus_if.req_hit = 1'b1; bus_if.rd_valid = 1'b1; bus_if.rd = 32'h12345678;
    @(negedge clk);
    bus_if.req_hit = 1'b0; bus_if.rd_valid = 1'b0;
    exp_done++; exp_err++;
    n_tests++;
    if (!ok || err !== 1'b1 || err_cnt !== 16'(exp_err) || err_addr !== addr2 || err_data !== 32'h12345678) begin
      n_fail++; $display("FAIL be_mask_miss: err=%0b err_cnt=%0d err_addr=%h err_data=%h, required 1/%0d/%h/12345678",
                         err, err_cnt, err_addr, err_data, exp_err, addr2);
    end
    @(negedge clk);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_pulse_width: err=%0b, required 0", err);
    end
  endtask

  task automatic test_back_to_back;
    cmd_t c;
    logic [31:0] addrs [9];
    for (int i = 0; i < 9; i++) begin
      addrs[i] = $urandom() & 32'hFFFF_FFFC;
      c = '{op: 1'b1, chk: 1'b0, addr: addrs[i], be: 4'hF, data: $urandom()};
      push_cmd(c);
    end
    n_tests++;
    if (cmd_ready !== 1'b0 || bus_if.write !== 1'b1) begin
      n_fail++; $display("FAIL b2b_full: ready=%0b wr=%0b, required 0/1", cmd_ready, bus_if.write);
    end
    bus_if.req_hit = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_tests++;
      if (bus_if.write !== 1'b1 || bus_if.a !== addrs[i]) begin
        n_fail++; $display("FAIL b2b_order[%0d]: wr=%0b a=%h, required 1/%h", i, bus_if.write, bus_if.a, addrs[i]);
      end
      @(negedge clk);
    end
    bus_if.req_hit = 1'b0;
    exp_done += 9;
    n_tests++;
    if (bus_if.write !== 1'b0 || done_cnt !== 16'(exp_done) || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_done: wr=%0b done=%0d busy=%0b ready=%0b, required 0/%0d/0/1",
                         bus_if.write, done_cnt, busy, cmd_ready, exp_done);
    end
  endtask

  task automatic test_random;
    localparam int N = 40;
    cmd_t q[$];
    fork
      begin : pusher
        cmd_t c;
        for (int i = 0; i < N; i++) begin
          c.op   = 1'($urandom_range(0, 1));
          c.chk  = ($urandom_range(0, 3) != 0);
          c.addr = $urandom() & 32'hFFFF_FFFC;
          c.be   = 4'($urandom_range(0, 15));
          c.data = $urandom();
          q.push_back(c);
          push_cmd(c);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin : responder
        cmd_t c; bit ok; bit mm;
        int hd; int rdly;
        logic [31:0] rdv;
        for (int i = 0; i < N; i++) begin
          wait_req(ok);
          n_tests++;
          if (!ok || q.size() == 0) begin
            n_fail++; $display("FAIL rnd_req[%0d]: no request within bound, queued=%0d", i, q.size());
            break;
          end
          c = q.pop_front();
          n_tests++;
          if ({bus_if.write, bus_if.read, bus_if.a, bus_if.be} !== {c.op, ~c.op, c.addr, c.be} ||
              (c.op && bus_if.wd !== c.data)) begin
            n_fail++; $display("FAIL rnd_bus[%0d]: wr=%0b rd=%0b a=%h be=%h wd=%h, required %0b/%0b/%h/%h/%h",
                               i, bus_if.write, bus_if.read, bus_if.a, bus_if.be, bus_if.wd,
                               c.op, ~c.op, c.addr, c.be, c.data);
          end
          hd = $urandom_range(0, 3);
          rdly = $urandom_range(0, 3);
          rdv = $urandom_range(0, 1) ? c.data : (c.data ^ (32'h1 << $urandom_range(0, 31)));
          repeat (hd) @(negedge clk);
          bus_if.req_hit = 1'b1;
          if (!c.op && rdly == 0) begin bus_if.rd_valid = 1'b1; bus_if.rd = rdv; end
          @(negedge clk);
          bus_if.req_hit = 1'b0; bus_if.rd_valid = 1'b0;
          if (!c.op && rdly > 0) begin
            repeat (rdly - 1) @(negedge clk);
            bus_if.rd_valid = 1'b1; bus_if.rd = rdv;
            @(negedge clk);
            bus_if.rd_valid = 1'b0;
          end
          mm = model_miss(c, rdv);
          exp_done++;
          if (mm) exp_err++;
          n_tests++;
          if (done_cnt !== 16'(exp_done) || err !== mm || err_cnt !== 16'(exp_err) ||
              (mm && (err_addr !== c.addr || err_data !== rdv))) begin
            n_fail++; $display("FAIL rnd_done[%0d]: done=%0d err=%0b err_cnt=%0d err_addr=%h err_data=%h, required %0d/%0b/%0d/%h/%h",
                               i, done_cnt, err, err_cnt, err_addr, err_data, exp_done, mm, exp_err, c.addr, rdv);
          end
          $display("[TB] txn %0d %s addr=%08h be=%h chk=%0b miss=%0b", i, c.op ? "WR" : "RD",
                   c.addr, c.be, c.chk, mm);
        end
      end
    join
  endtask

  task automatic test_reset_mid;
    cmd_t c; bit ok;
    c = '{op: 1'b0, chk: 1'b1, addr: 32'h400, be: 4'hF, data: 32'h0};
    push_cmd(c);
    wait_req(ok);
    bus_if.req_hit = 1'b1;
    @(negedge clk);
    bus_if.req_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c = '{op: 1'b1, chk: 1'b0, addr: 32'h500 + 32'(4 * i), be: 4'hF, data: $urandom()};
      push_cmd(c);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus_if.read, bus_if.write, busy, cmd_ready, err, timeout} !== 6'b0 || bus_if.a !== 32'd0 ||
        bus_if.wd !== 32'd0 || bus_if.be !== 4'd0 || done_cnt !== 16'd0 || err_cnt !== 16'd0 ||
        err_addr !== 32'd0 || err_data !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_async: rd=%0b wr=%0b busy=%0b ready=%0b a=%h done=%0d err_cnt=%0d, required all 0",
                         bus_if.read, bus_if.write, busy, cmd_ready, bus_if.a, done_cnt, err_cnt);
    end
    exp_done = 0; exp_err = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_release: busy=%0b ready=%0b, required 0/1", busy, cmd_ready);
    end
    bus_if.rd_valid = 1'b1; bus_if.rd = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_if.rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (done_cnt !== 16'd0 || err_cnt !== 16'd0 || busy !== 1'b0 || bus_if.read !== 1'b0 || bus_if.write !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_late_rd: done=%0d err_cnt=%0d busy=%0b rd=%0b wr=%0b, required 0/0/0/0/0",
                         done_cnt, err_cnt, busy, bus_if.read, bus_if.write);
    end
  endtask

  task automatic test_timeout;
    cmd_t c; bit ok; int cnt;
    c = '{op: 1'b0, chk: 1'b1, addr: 32'h600, be: 4'hF, data: 32'h1};
    push_cmd(c);
    wait_req(ok);
    cnt = 0;
    while (bus_if.read && cnt < 100) begin cnt++; @(negedge clk); end
    n_tests++;
    if (!ok || cnt != TO) begin
      n_fail++; $display("FAIL timeout_cycles: read high %0d cycles, required %0d", cnt, TO);
    end
    n_tests++;
    if (timeout !== 1'b1 || bus_if.read !== 1'b0 || cmd_ready !== 1'b0 || done_cnt !== 16'(exp_done)) begin
      n_fail++; $display("FAIL timeout_halt: timeout=%0b rd=%0b ready=%0b done=%0d, required 1/0/0/%0d",
                         timeout, bus_if.read, cmd_ready, done_cnt, exp_done);
    end
    cmd_valid = 1'b1; cmd_op = 1'b1;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    n_tests++;
    if (timeout !== 1'b1 || bus_if.write !== 1'b0 || bus_if.read !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL timeout_sticky: timeout=%0b wr=%0b rd=%0b ready=%0b, required 1/0/0/0",
                         timeout, bus_if.write, bus_if.read, cmd_ready);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (timeout !== 1'b0) begin
      n_fail++; $display("FAIL timeout_clear: timeout=%0b, required 0", timeout);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_recover: ready=%0b busy=%0b, required 1/0", cmd_ready, busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_be_mask();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_req_gen.md
# cache_req_gen

CPU-side request initiator for the L1 `cache` block, driving the port that the bench currently drives from tasks. It accepts a queue of read/write commands, issues them one at a time on the cache request interface (`a/be/read/write/wd`), and holds each request until the cache accepts it. It collects read data, compares it against expected values under byte-enable mask, and reports completion, error and timeout status. This lets directed and random cache tests run from a command stream instead of hand-timed tasks.

## Interface
- DEPTH, 8: command FIFO entries (power of 2, ≥2).
- TIMEOUT, 255: max cycles a request waits for `req_hit` or `rd_valid` before halting.
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low; clears all state and outputs.
- cmd_valid  input  1  command push request.
- cmd_ready  output  1  FIFO can accept (not full, not halted).
- cmd_op  input  1  0 = read, 1 = write.
- cmd_chk  input  1  read only: compare returned data.
- cmd_addr  input  32  byte address.
- cmd_be  input  4  byte enables.
- cmd_data  input  32  write data, or expected read data.
- a  output  32  request address to cache.
- be  output  4  request byte enables.
- read  output  1  read request, level, held until accepted.
- write  output  1  write request, level, held until accepted.
- wd  output  32  write data.
- rd  input  32  cache read data.
- rd_valid  input  1  `rd` valid this cycle.
- req_hit  input  1  cache accepts the current request at this edge.
- busy  output  1  FIFO non-empty or request outstanding.
- done_cnt  output  16  completed commands, saturating.
- err_cnt  output  16  read compare mismatches, saturating.
- err  output  1  one-cycle pulse on mismatch.
- err_addr  output  32  address of most recent mismatch.
- err_data  output  32  actual `rd` of most recent mismatch.
- timeout  output  1  sticky; set on timeout, cleared only by reset.

## Operation
- FIFO: push on `cmd_valid & cmd_ready`. `cmd_ready = !full & state!=HALT`. Entry = {op,chk,addr,be,data}. A push to a full FIFO is impossible because `cmd_ready` is low.
- States:
  - IDLE: if the FIFO is non-empty, pop the head into the request registers and go to ISSUE.
  - ISSUE: drive `read` or `write` with stable `a/be/wd`.
    - On an edge with `req_hit=1` and a write: `done_cnt++`. If the FIFO is non-empty, pop the next entry and stay in ISSUE (back-to-back). Otherwise go to IDLE.
    - On an edge with `req_hit=1` and a read: if `rd_valid=1` at the same edge, complete now, same as a write. Otherwise go to WAIT_RD.
  - WAIT_RD: `read`/`write` low. On `rd_valid`, complete (compare, `done_cnt++`), then pop the next entry to ISSUE or go to IDLE.
  - HALT: `read/write=0`, no pops, no pushes. Exit only by reset.
- Compare: `mask = {{8{be[3]}},{8{be[2]}},{8{be[1]}},{8{be[0]}}}`. Mismatch when `chk & ((rd^exp)&mask)!=0`. On mismatch:
  - `err=1` for the completion cycle;
  - `err_cnt++`;
  - `err_addr`/`err_data` load.
  - `chk=0` or `be=0` never errors.
- Timeout counter: 8+ bits wide enough for TIMEOUT. Cleared on each entry into ISSUE/WAIT_RD and on each accept. It increments every cycle in ISSUE/WAIT_RD. When it reaches TIMEOUT: `timeout=1` and state goes to HALT, with no completion counted.
- Counters saturate at 16'hFFFF and never wrap.
- `rd_valid` in IDLE or while a write is in ISSUE is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, FIFO empty, counters 0. `cmd_ready` is 0 while reset is asserted and 1 from the first edge after release.
- Push at edge N: the entry is poppable at edge N+1. `read`/`write` is high from edge N+2.
- `a/be/wd/read/write` are registered outputs and are stable while a request is pending.
- Write hit throughput: 1 request/cycle with `req_hit` held 1.
- Read completion: on the `rd_valid` edge. `err` and the `done_cnt`/`err_cnt` updates are visible in the following cycle.
- `busy` drops the cycle after the last completion when the FIFO is empty.
- Reset asserted mid-request: outputs go to 0 asynchronously. The outstanding request is abandoned and the FIFO contents are discarded.

## Test plan
- Write 0x100, be F, data 0xA5A5A5A5; `req_hit` asserted in the 1st cycle `write` is high -> `write` high exactly 1 cycle, `a=0x100`, `wd=0xA5A5A5A5`, `done_cnt=1`, `busy` then 0.
- Read 0x200, chk, exp 0xDEADBEEF; `req_hit` at first cycle, `rd_valid`+`rd=0xDEADBEEF` 1 cycle later -> `done_cnt=1`, `err_cnt=0`, `err` never high.
- Read with be=4'b0011:
  - rd=0x12345678, exp 0xFFFF5678 -> no error;
  - rd=0x12345678, exp 0x12340000 -> one `err` pulse, `err_cnt=1`, `err_addr` = read address, `err_data=0x12345678`.
- Push 9 writes with `req_hit` low -> `cmd_ready` low after 8 FIFO entries plus 1 in ISSUE. Then raise `req_hit` -> 9 writes accepted on 9 consecutive edges, addresses in order, `done_cnt=9`.
- Read with `req_hit` never asserted, TIMEOUT=16 -> `timeout=1` after 16 cycles in ISSUE, `read=0`, `cmd_ready=0`, `done_cnt` unchanged, persists until reset.
- Reset asserted during WAIT_RD with 3 queued commands -> all outputs 0 immediately. After release: FIFO empty, `busy=0`, `cmd_ready=1`. A late `rd_valid` is ignored.
